// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - parametrised register file with pending scoreboard and write-to-read bypass
// Two async read ports, one sync write port, one reserve port marking a destination in-flight.
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    reg_write,
    input  logic [ADDR_W-1:0]       write_addr,
    input  logic [DATA_W-1:0]       write_data,
    input  logic [ADDR_W-1:0]       read_addr_1,
    input  logic [ADDR_W-1:0]       read_addr_2,
    output logic [DATA_W-1:0]       read_data_1,
    output logic [DATA_W-1:0]       read_data_2,
    output logic                    read_ready_1,
    output logic                    read_ready_2,
    input  logic                    rsv_valid,
    input  logic [ADDR_W-1:0]       rsv_addr,
    output logic                    rsv_conflict,
    output logic [(1<<ADDR_W)-1:0]  busy_mask
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  pending_q;
    logic [NREGS-1:0]  pending_d;

    logic wr_prot;
    logic rsv_prot;
    logic wr_en;
    logic rsv_take;

    assign wr_prot  = (ZERO_REG != 0) && (write_addr == '0);
    assign rsv_prot = (ZERO_REG != 0) && (rsv_addr == '0);
    assign wr_en    = reg_write && !wr_prot;

    // A write landing on the same register releases the old reservation, so a new one may take it.
    assign rsv_conflict = rsv_valid && !rsv_prot && pending_q[rsv_addr]
                          && !(reg_write && (write_addr == rsv_addr));
    assign rsv_take     = rsv_valid && !rsv_prot && !rsv_conflict;

    always_comb begin
        pending_d = pending_q;
        if (wr_en) begin
            pending_d[write_addr] = 1'b0;
        end
        // Reserve applied after the write clear so a same-cycle reservation wins.
        if (rsv_take) begin
            pending_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            if (wr_en) begin
                regs_q[write_addr] <= write_data;
            end
            pending_q <= pending_d;
        end
    end

    logic [ADDR_W-1:0] rd_addr  [2];
    logic [DATA_W-1:0] rd_data  [2];
    logic              rd_ready [2];

    assign rd_addr[0] = read_addr_1;
    assign rd_addr[1] = read_addr_2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            rd_data[p]  = regs_q[rd_addr[p]];
            rd_ready[p] = !pending_q[rd_addr[p]];
            if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
                rd_data[p]  = '0;
                rd_ready[p] = 1'b1;
            end else if ((BYPASS != 0) && reg_write && (write_addr == rd_addr[p])) begin
                rd_data[p]  = write_data;
                rd_ready[p] = 1'b1;
            end
        end
    end

    assign read_data_1  = rd_data[0];
    assign read_data_2  = rd_data[1];
    assign read_ready_1 = rd_ready[0];
    assign read_ready_2 = rd_ready[1];
    assign busy_mask    = pending_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - random and directed bench for reg_file_sb against a behavioural model
// Instances: 0 = defaults, 1 = BYPASS=0, 2 = DATA_W=32 / ADDR_W=4.
module tb_reg_file_sb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s_we  [3];
    logic [3:0]  s_wa  [3];
    logic [31:0] s_wd  [3];
    logic [3:0]  s_ra1 [3];
    logic [3:0]  s_ra2 [3];
    logic        s_rv  [3];
    logic [3:0]  s_rsa [3];

    logic [15:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic [31:0] rd1_c, rd2_c;
    logic [2:0]  rr1, rr2, conf;
    logic [7:0]  busy_a, busy_b;
    logic [15:0] busy_c;

    reg_file_sb u_a (
        .clk(clk), .rst(rst), .reg_write(s_we[0]), .write_addr(s_wa[0][2:0]),
        .write_data(s_wd[0][15:0]), .read_addr_1(s_ra1[0][2:0]), .read_addr_2(s_ra2[0][2:0]),
        .read_data_1(rd1_a), .read_data_2(rd2_a), .read_ready_1(rr1[0]), .read_ready_2(rr2[0]),
        .rsv_valid(s_rv[0]), .rsv_addr(s_rsa[0][2:0]), .rsv_conflict(conf[0]), .busy_mask(busy_a)
    );

    reg_file_sb #(.BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .reg_write(s_we[1]), .write_addr(s_wa[1][2:0]),
        .write_data(s_wd[1][15:0]), .read_addr_1(s_ra1[1][2:0]), .read_addr_2(s_ra2[1][2:0]),
        .read_data_1(rd1_b), .read_data_2(rd2_b), .read_ready_1(rr1[1]), .read_ready_2(rr2[1]),
        .rsv_valid(s_rv[1]), .rsv_addr(s_rsa[1][2:0]), .rsv_conflict(conf[1]), .busy_mask(busy_b)
    );

    reg_file_sb #(.DATA_W(32), .ADDR_W(4)) u_c (
        .clk(clk), .rst(rst), .reg_write(s_we[2]), .write_addr(s_wa[2]),
        .write_data(s_wd[2]), .read_addr_1(s_ra1[2]), .read_addr_2(s_ra2[2]),
        .read_data_1(rd1_c), .read_data_2(rd2_c), .read_ready_1(rr1[2]), .read_ready_2(rr2[2]),
        .rsv_valid(s_rv[2]), .rsv_addr(s_rsa[2]), .rsv_conflict(conf[2]), .busy_mask(busy_c)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] m_regs [3][16];
    bit          m_pend [3][16];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nregs(input int k);
        return (k == 2) ? 16 : 8;
    endfunction

    function automatic logic [31:0] dmask(input int k);
        return (k == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic logic [31:0] obs_rd(input int k, input int port);
        case (k)
            0:       return (port == 1) ? {16'h0, rd1_a} : {16'h0, rd2_a};
            1:       return (port == 1) ? {16'h0, rd1_b} : {16'h0, rd2_b};
            default: return (port == 1) ? rd1_c : rd2_c;
        endcase
    endfunction

    function automatic logic [15:0] obs_busy(input int k);
        case (k)
            0:       return {8'h0, busy_a};
            1:       return {8'h0, busy_b};
            default: return busy_c;
        endcase
    endfunction

    function automatic void exp_read(input int k, input int ra,
                                     output logic [31:0] d, output logic r);
        if (ra == 0) begin
            d = 32'h0; r = 1'b1;
        end else if (k != 1 && s_we[k] && int'(s_wa[k]) == ra) begin
            d = s_wd[k] & dmask(k); r = 1'b1;
        end else begin
            d = m_regs[k][ra]; r = !m_pend[k][ra];
        end
    endfunction

    function automatic bit exp_conflict(input int k);
        int a = int'(s_rsa[k]);
        return s_rv[k] && a != 0 && m_pend[k][a] && !(s_we[k] && int'(s_wa[k]) == a);
    endfunction

    task automatic model_check(input int k);
        logic [31:0] d;
        logic        r;
        logic [15:0] eb = '0;
        exp_read(k, int'(s_ra1[k]), d, r);
        check_eq($sformatf("i%0d_rd1_a%0d", k, s_ra1[k]), {32'h0, obs_rd(k, 1)}, {32'h0, d});
        check_eq($sformatf("i%0d_rdy1_a%0d", k, s_ra1[k]), {63'h0, rr1[k]}, {63'h0, r});
        exp_read(k, int'(s_ra2[k]), d, r);
        check_eq($sformatf("i%0d_rd2_a%0d", k, s_ra2[k]), {32'h0, obs_rd(k, 2)}, {32'h0, d});
        check_eq($sformatf("i%0d_rdy2_a%0d", k, s_ra2[k]), {63'h0, rr2[k]}, {63'h0, r});
        check_eq($sformatf("i%0d_conflict", k), {63'h0, conf[k]}, {63'h0, exp_conflict(k)});
        for (int i = 0; i < nregs(k); i++) eb[i] = m_pend[k][i];
        check_eq($sformatf("i%0d_busy", k), {48'h0, obs_busy(k)}, {48'h0, eb});
    endtask

    task automatic model_step(input int k);
        bit c;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_regs[k][i] = 32'h0;
                m_pend[k][i] = 1'b0;
            end
        end else begin
            c = exp_conflict(k);
            if (s_we[k] && s_wa[k] != 0) begin
                m_regs[k][s_wa[k]] = s_wd[k] & dmask(k);
                m_pend[k][s_wa[k]] = 1'b0;
            end
            if (s_rv[k] && s_rsa[k] != 0 && !c) m_pend[k][s_rsa[k]] = 1'b1;
        end
    endtask

    task automatic settle();
        #4;
        for (int k = 0; k < 3; k++) model_check(k);
    endtask

    task automatic clock();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
    endtask

    task automatic set_all(input logic we, input int wa, input logic [15:0] wd,
                           input int ra1, input int ra2, input logic rv, input int rsa);
        for (int k = 0; k < 3; k++) begin
            s_we[k]  = we;
            s_wa[k]  = 4'(wa);
            s_wd[k]  = (k == 2) ? {wd ^ 16'h5A5A, wd} : {16'h0, wd};
            s_ra1[k] = 4'(ra1);
            s_ra2[k] = 4'(ra2);
            s_rv[k]  = rv;
            s_rsa[k] = 4'(rsa);
        end
    endtask

    initial begin
        rst = 1'b1;
        set_all(1'b0, 0, 16'h0, 0, 0, 1'b0, 0);
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        rst = 1'b0;

        // reset state sweep
        for (int a = 0; a < 16; a++) begin
            set_all(1'b0, 0, 16'h0, a & 7, a & 7, 1'b0, 0);
            s_ra1[2] = 4'(a);
            s_ra2[2] = 4'(15 - a);
            settle();
            check_eq("rst_rdy1", {63'h0, rr1[2]}, 64'h1);
            clock();
        end

        // write r5 then read, bypass vs no bypass
        set_all(1'b1, 5, 16'hBEEF, 5, 1, 1'b0, 0);
        settle();
        check_eq("byp_same_cycle", {48'h0, rd1_a}, 64'hBEEF);
        check_eq("nobyp_same_cycle", {48'h0, rd1_b}, 64'h0);
        clock();
        set_all(1'b0, 0, 16'h0, 5, 5, 1'b0, 0);
        settle();
        check_eq("byp_next", {48'h0, rd1_a}, 64'hBEEF);
        check_eq("nobyp_next", {48'h0, rd1_b}, 64'hBEEF);
        clock();

        // reserve r3, conflict, clear by write
        set_all(1'b0, 0, 16'h0, 1, 3, 1'b1, 3);
        settle();
        clock();
        set_all(1'b0, 0, 16'h0, 1, 3, 1'b0, 0);
        settle();
        check_eq("rsv_busy3", {63'h0, busy_a[3]}, 64'h1);
        check_eq("rsv_rdy2", {63'h0, rr2[0]}, 64'h0);
        clock();
        set_all(1'b0, 0, 16'h0, 1, 3, 1'b1, 3);
        settle();
        check_eq("rsv_again_conflict", {63'h0, conf[0]}, 64'h1);
        clock();
        set_all(1'b1, 3, 16'h0042, 1, 3, 1'b0, 0);
        settle();
        check_eq("clear_byp_rdy", {63'h0, rr2[0]}, 64'h1);
        check_eq("clear_nobyp_rdy", {63'h0, rr2[1]}, 64'h0);
        clock();
        set_all(1'b0, 0, 16'h0, 1, 3, 1'b0, 0);
        settle();
        check_eq("clear_nobyp_data", {48'h0, rd2_b}, 64'h0042);
        clock();

        // same-cycle write and reserve while pending
        set_all(1'b0, 0, 16'h0, 2, 2, 1'b1, 2);
        settle();
        clock();
        set_all(1'b1, 2, 16'h1234, 1, 1, 1'b1, 2);
        settle();
        check_eq("wr_rsv_no_conflict", {63'h0, conf[0]}, 64'h0);
        clock();
        set_all(1'b0, 0, 16'h0, 2, 2, 1'b0, 0);
        settle();
        check_eq("wr_rsv_data", {48'h0, rd1_b}, 64'h1234);
        check_eq("wr_rsv_busy2", {63'h0, busy_a[2]}, 64'h1);
        clock();

        // zero register
        set_all(1'b1, 0, 16'hFFFF, 0, 0, 1'b1, 0);
        settle();
        check_eq("r0_data", {48'h0, rd1_a}, 64'h0);
        check_eq("r0_conflict", {63'h0, conf[0]}, 64'h0);
        clock();
        set_all(1'b0, 0, 16'h0, 0, 0, 1'b0, 0);
        settle();
        check_eq("r0_busy", {63'h0, busy_a[0]}, 64'h0);
        clock();

        // reset priority over write and reserve
        set_all(1'b0, 0, 16'h0, 4, 4, 1'b1, 4);
        settle();
        clock();
        rst = 1'b1;
        set_all(1'b1, 7, 16'hAAAA, 7, 6, 1'b1, 6);
        clock();
        rst = 1'b0;
        for (int a = 0; a < 16; a++) begin
            set_all(1'b0, 0, 16'h0, a & 7, (a + 3) & 7, 1'b0, 0);
            s_ra1[2] = 4'(a);
            settle();
            clock();
        end
        check_eq("rstprio_busy_c", {48'h0, busy_c}, 64'h0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            for (int k = 0; k < 3; k++) begin
                s_we[k]  = 1'($urandom_range(0, 1));
                s_wa[k]  = 4'($urandom_range(0, nregs(k) - 1));
                s_wd[k]  = $urandom();
                s_ra1[k] = 4'($urandom_range(0, nregs(k) - 1));
                s_ra2[k] = ($urandom_range(0, 3) == 0) ? s_wa[k]
                                                       : 4'($urandom_range(0, nregs(k) - 1));
                s_rv[k]  = 1'($urandom_range(0, 1));
                s_rsa[k] = ($urandom_range(0, 3) == 0) ? s_wa[k]
                                                       : 4'($urandom_range(0, nregs(k) - 1));
                if (k < 2) s_wd[k] = s_wd[k] & 32'h0000_FFFF;
            end
            settle();
            clock();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
